// File: rtl/rng_pkg.sv
// ============================================================================
// rng_pkg : shared FSM type, maximal-length Galois taps and mask helper
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } rng_state_t;

    localparam logic [7:0]  c_taps_w8  = 8'hB8;
    localparam logic [15:0] c_taps_w16 = 16'hB400;
    localparam logic [23:0] c_taps_w24 = 24'hE10000;
    localparam logic [31:0] c_taps_w32 = 32'h80200003;

    // Smallest 2^k-1 that is >= max.
    function automatic logic [31:0] mask_for(input logic [31:0] max);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (m < max) begin
                m = {m[30:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// lfsr_core : Galois LFSR state register with seed load and zero-seed guard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             lockup_err
);

    logic [WIDTH-1:0] r_state;
    logic             r_lockup;
    logic [WIDTH-1:0] w_next;

    generate
        if (SEED == '0) begin : g_chk_seed
            $error("lfsr_core: SEED must be nonzero");
        end
        if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
            $error("lfsr_core: TAPS[WIDTH-1] must be 1");
        end
    endgenerate

    always_comb begin
        w_next = r_state >> 1;
        if (r_state[0]) begin
            w_next = w_next ^ TAPS;
        end
    end

    // A zero seed would lock the register at zero forever, so SEED is substituted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= SEED;
            r_lockup <= 1'b0;
        end else if (seed_we) begin
            if (seed_in == '0) begin
                r_state  <= SEED;
                r_lockup <= 1'b1;
            end else begin
                r_state  <= seed_in;
            end
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state      = r_state;
    assign lockup_err = r_lockup;

endmodule

`default_nettype wire

// File: rtl/lfsr_range_rng.sv
// ============================================================================
// lfsr_range_rng : LFSR random draws in 0..req_max via rejection sampling
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lfsr_range_rng
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_max,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [OUT_W-1:0] rnd_data,
    output logic [WIDTH-1:0] lfsr_state,
    output logic             lockup_err
);

    localparam int c_try_w = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [c_try_w-1:0] c_last_try = c_try_w'(MAX_TRIES - 1);

    generate
        if (OUT_W > WIDTH || OUT_W > 32) begin : g_chk_out_w
            $error("lfsr_range_rng: OUT_W must be <= WIDTH and <= 32");
        end
        if (MAX_TRIES < 1) begin : g_chk_tries
            $error("lfsr_range_rng: MAX_TRIES must be >= 1");
        end
    endgenerate

    rng_state_t       r_fsm;
    rng_state_t       w_fsm_next;
    logic [OUT_W-1:0] r_max;
    logic [OUT_W-1:0] r_mask;
    logic [OUT_W-1:0] r_data;
    logic [c_try_w-1:0] r_tries;
    logic [OUT_W-1:0] w_cand;
    logic [OUT_W-1:0] w_fallback;
    logic             w_hit;
    logic             w_last;
    logic             w_step;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .step       (w_step),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .state      (lfsr_state),
        .lockup_err (lockup_err)
    );

    assign w_step     = enable || (r_fsm == ST_DRAW);
    assign w_cand     = lfsr_state[OUT_W-1:0] & r_mask;
    assign w_hit      = (w_cand <= r_max);
    assign w_last     = (r_tries == c_last_try);
    // Only used on a rejection, so w_cand > r_max and mask < 2*(max+1) keep it in range.
    assign w_fallback = w_cand - r_max - OUT_W'(1);

    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            ST_IDLE: if (req_valid)        w_fsm_next = ST_DRAW;
            ST_DRAW: if (w_hit || w_last)  w_fsm_next = ST_DONE;
            ST_DONE: if (rnd_ready)        w_fsm_next = ST_IDLE;
            default:                       w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max   <= '0;
            r_mask  <= '0;
            r_tries <= '0;
            r_data  <= '0;
        end else begin
            if (r_fsm == ST_IDLE && req_valid) begin
                r_max   <= req_max;
                r_mask  <= OUT_W'(mask_for(32'(req_max)));
                r_tries <= '0;
            end
            if (r_fsm == ST_DRAW) begin
                if (w_hit) begin
                    r_data <= w_cand;
                end else if (w_last) begin
                    r_data <= w_fallback;
                end else begin
                    r_tries <= r_tries + c_try_w'(1);
                end
            end
        end
    end

    assign req_ready = (r_fsm == ST_IDLE);
    assign rnd_valid = (r_fsm == ST_DONE);
    assign rnd_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_range_rng.sv
// ============================================================================
// tb_lfsr_range_rng : directed + randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lfsr_range_rng;

    localparam int          MAX_TRIES = 8;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic        seed_we   = 1'b0;
    logic [15:0] seed_in   = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_max   = '0;
    logic        rnd_valid;
    logic        rnd_ready = 1'b0;
    logic [7:0]  rnd_data;
    logic [15:0] lfsr_state;
    logic        lockup_err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] m_state;

    always #5 clk = ~clk;

    lfsr_range_rng #(
        .WIDTH     (16),
        .TAPS      (TAPS),
        .SEED      (SEED),
        .OUT_W     (8),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_we    (seed_we),
        .seed_in    (seed_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_max    (req_max),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .lfsr_state (lfsr_state),
        .lockup_err (lockup_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    function automatic int mask_of(input int max);
        int m;
        m = 0;
        while (m < max) m = m * 2 + 1;
        return m;
    endfunction

    // Attempt t uses the state after t-1 steps; each attempt advances the LFSR once.
    function automatic void ref_draw(input logic [15:0] s0, input int max,
                                     output int res, output int k, output logic [15:0] s_end);
        logic [15:0] s;
        int m, cand;
        s = s0;
        m = mask_of(max);
        res = 0;
        k = MAX_TRIES;
        for (int t = 1; t <= MAX_TRIES; t++) begin
            cand = int'(s[7:0]) & m;
            s = ref_step(s);
            if (cand <= max) begin
                res = cand;
                k = t;
                s_end = s;
                return;
            end
            if (t == MAX_TRIES) res = cand - (max + 1);
        end
        s_end = s;
    endfunction

    task automatic do_draw(input int max, input int max_stall);
        int          res, k, lat, nstall;
        logic [15:0] s_end;
        logic [7:0]  held;
        bit          stable;
        check("req_ready_idle", req_ready, 1);
        ref_draw(m_state, max, res, k, s_end);
        req_valid = 1'b1;
        req_max   = max[7:0];
        tick();
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 0);
        lat = 0;
        while (!rnd_valid && lat <= MAX_TRIES + 1) begin
            tick();
            lat++;
        end
        check("latency", lat, k);
        check("rnd_data", rnd_data, res);
        check("in_range", rnd_data <= max, 1);
        held   = rnd_data;
        stable = 1'b1;
        nstall = $urandom_range(max_stall);
        for (int i = 0; i < nstall; i++) begin
            tick();
            if (rnd_data !== held || rnd_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        m_state = s_end;
        check("valid_drop", rnd_valid, 0);
        check("state_after", lfsr_state, m_state);
    endtask

    initial begin
        logic [15:0] exp4 [4];
        int          zero_seen, mism;
        exp4 = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E};

        // Reset state
        repeat (2) tick();
        check("rst_state", lfsr_state, SEED);
        check("rst_req_ready", req_ready, 1);
        check("rst_rnd_valid", rnd_valid, 0);
        check("rst_rnd_data", rnd_data, 0);
        check("rst_lockup", lockup_err, 0);
        reset = 1'b0;
        tick();
        check("idle_hold", lfsr_state, SEED);

        // Free-running steps
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("step4", lfsr_state, exp4[i]);
        end
        m_state   = 16'h1C4E;
        zero_seen = 0;
        mism      = 0;
        for (int i = 4; i < 65535; i++) begin
            tick();
            m_state = ref_step(m_state);
            if (lfsr_state == 16'h0000) zero_seen++;
            if (lfsr_state !== m_state) mism++;
        end
        enable = 1'b0;
        check("period_wrap", lfsr_state, SEED);
        check("period_no_zero", zero_seen, 0);
        check("period_model", mism, 0);

        // Zero-seed protection and seed priority
        seed_in = 16'h0000;
        seed_we = 1'b1;
        tick();
        seed_we = 1'b0;
        check("zero_seed_state", lfsr_state, SEED);
        check("zero_seed_lockup", lockup_err, 1);
        repeat (3) tick();
        check("lockup_sticky", lockup_err, 1);
        enable  = 1'b1;
        seed_we = 1'b1;
        seed_in = 16'h1234;
        tick();
        seed_we = 1'b0;
        enable  = 1'b0;
        check("seed_priority", lfsr_state, 16'h1234);
        check("lockup_after_seed", lockup_err, 1);
        m_state = 16'h1234;

        // Draws
        repeat (1000) do_draw(5, 3);
        repeat (200)  do_draw(int'($urandom_range(255)), 2);
        repeat (100)  do_draw(128, 1);
        do_draw(255, 0);
        do_draw(0, 0);

        // req_max=0 then asynchronous reset while the result is pending
        req_valid = 1'b1;
        req_max   = 8'd0;
        tick();
        req_valid = 1'b0;
        tick();
        m_state = ref_step(m_state);
        check("max0_valid", rnd_valid, 1);
        check("max0_data", rnd_data, 0);
        check("max0_state", lfsr_state, m_state);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", rnd_valid, 0);
        check("async_rst_state", lfsr_state, SEED);
        check("async_rst_ready", req_ready, 1);
        check("async_rst_data", rnd_data, 0);
        check("async_rst_lockup", lockup_err, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
